// File: rtl/mem_port_arb_if.sv
// rtl/mem_port_arb_if.sv - fetch/data requester and memory port bundle for mem_port_arb
// master is the arbiter side; slave is the pipeline plus memory side.
interface mem_port_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_stall;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          dm_stall;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport master (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_stall,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport slave (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_stall,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - single-port memory arbiter between IF fetches and MEM loads/stores
// One transaction at a time: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP.
module mem_port_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_port_arb_if.master bus
);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [LW-1:0] lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          gnt_d;
    logic          if_ack;
    logic          dm_ack;
    logic          mem_en;
    logic          mem_we;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] if_rdata;
    logic [DW-1:0] dm_rdata;
    logic          pick_d;

    // Data is the older instruction and normally wins; a starved fetch overrides it.
    always_comb begin
        pick_d = bus.dm_req & ~(bus.if_req & (starve_cnt == STARVE_LIM));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            gnt_d      <= 1'b0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    if (bus.if_req || bus.dm_req) begin
                        gnt_d     <= pick_d;
                        mem_addr  <= pick_d ? bus.dm_addr : bus.if_addr;
                        mem_wdata <= pick_d ? bus.dm_wdata : '0;
                        mem_we    <= pick_d & bus.dm_we;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                        if (pick_d && bus.if_req) begin
                            if (starve_cnt != STARVE_LIM) begin
                                starve_cnt <= starve_cnt + SW'(1);
                            end
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                ACCESS: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (gnt_d) begin
                            dm_rdata <= bus.mem_rdata;
                        end else begin
                            if_rdata <= bus.mem_rdata;
                        end
                        if_ack <= ~gnt_d;
                        dm_ack <= gnt_d;
                        state  <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end
                RESP: begin
                    // Always return to IDLE so a still-high request is not re-granted here.
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_ack    = if_ack;
    assign bus.if_rdata  = if_rdata;
    assign bus.if_stall  = bus.if_req & ~if_ack;
    assign bus.dm_ack    = dm_ack;
    assign bus.dm_rdata  = dm_rdata;
    assign bus.dm_stall  = bus.dm_req & ~dm_ack;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - scoreboard bench for mem_port_arb
`timescale 1ns/1ps
module tb_mem_port_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arb_if #(.AW(32), .DW(32)) bus  ();
    mem_port_arb_if #(.AW(32), .DW(32)) bus1 ();

    mem_port_arb #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_port_arb #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 'h40) return 32'hDEADBEEF;
        return 32'hC0DE0000 + 32'(idx) * 32'h11;
    endfunction

    // Memory models: sample at end of mem_en cycle, data valid MEM_LAT cycles after it.
    logic [31:0] mem [0:255];
    logic [31:0] rp1, rp2, rq1;
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
            mem_loaded = 1'b1;
        end
        if (bus.mem_en) begin
            rp1 <= mem[bus.mem_addr[9:2]];
            if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
        end
        rp2 <= rp1;
        if (bus1.mem_en) rq1 <= mem[bus1.mem_addr[9:2]];
    end
    assign bus.mem_rdata  = rp2;
    assign bus1.mem_rdata = rq1;

    logic [32:0] if_q[$];
    logic [32:0] dm_q[$];
    logic [32:0] dm1_q[$];
    int          ack_log[$];
    int          en_cnt = 0, wr_cnt = 0, en1_cnt = 0;
    logic [32:0] it;

    always @(negedge clk) begin
        if (bus.mem_en) en_cnt++;
        if (bus.mem_en && bus.mem_we) wr_cnt++;
        if (bus1.mem_en) en1_cnt++;
        if (bus.if_ack) begin
            ack_log.push_back(0);
            check("if_ack_expected", 64'(if_q.size() != 0), 64'd1);
            if (if_q.size() != 0) begin
                it = if_q.pop_front();
                if (it[32]) check("if_rdata", 64'(bus.if_rdata), 64'(it[31:0]));
            end
        end
        if (bus.dm_ack) begin
            ack_log.push_back(1);
            check("dm_ack_expected", 64'(dm_q.size() != 0), 64'd1);
            if (dm_q.size() != 0) begin
                it = dm_q.pop_front();
                if (it[32]) check("dm_rdata", 64'(bus.dm_rdata), 64'(it[31:0]));
            end
        end
        if (bus1.dm_ack) begin
            check("dm1_ack_expected", 64'(dm1_q.size() != 0), 64'd1);
            if (dm1_q.size() != 0) begin
                it = dm1_q.pop_front();
                if (it[32]) check("dm1_rdata", 64'(bus1.dm_rdata), 64'(it[31:0]));
            end
        end
    end

    task automatic wait_ack(input int which, output int when);
        bit seen = 1'b0;
        when = -1;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if ((which == 0 && bus.if_ack) || (which == 1 && bus.dm_ack) ||
                (which == 2 && bus1.dm_ack)) begin
                seen = 1'b1;
                when = cyc;
            end
        end
        check($sformatf("ack_in_time_%0d", which), 64'(seen), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int c0, ca, cb, cd, ci, e0, w0, acks;
    int exp_order[7] = '{1, 1, 1, 1, 0, 1, 1};

    initial begin
        bus.if_req = 0;  bus.if_addr = '0;
        bus.dm_req = 0;  bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus1.if_req = 0; bus1.if_addr = '0;
        bus1.dm_req = 0; bus1.dm_we = 0; bus1.dm_addr = '0; bus1.dm_wdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en",    64'(bus.mem_en), 64'd0);
        check("rst_mem_we",    64'(bus.mem_we), 64'd0);
        check("rst_busy",      64'(bus.busy), 64'd0);
        check("rst_acks",      64'({bus.if_ack, bus.dm_ack}), 64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_rdata",     64'({bus.if_rdata, bus.dm_rdata}), 64'd0);
        check("rst_starve",    64'(dut.starve_cnt), 64'd0);
        @(posedge clk); #1 rst_n = 1;

        // Single fetch
        @(posedge clk); #1;
        c0 = cyc;
        bus.if_req = 1; bus.if_addr = 32'h100;
        if_q.push_back({1'b1, 32'hDEADBEEF});
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("t1_if_stall_c%0d", k), 64'(bus.if_stall), 64'(k < 4));
            check($sformatf("t1_if_ack_c%0d", k),   64'(bus.if_ack), 64'(k == 4));
            check($sformatf("t1_mem_en_c%0d", k),   64'(bus.mem_en), 64'(k == 1));
            if (k == 1) begin
                check("t1_mem_addr", 64'(bus.mem_addr), 64'h100);
                check("t1_mem_we",   64'(bus.mem_we), 64'd0);
            end
        end
        check("t1_if_rdata", 64'(bus.if_rdata), 64'hDEADBEEF);
        @(posedge clk); #1 bus.if_req = 0;

        // Store then load, back to back
        @(posedge clk); #1;
        w0 = wr_cnt; e0 = en_cnt;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h12345678;
        dm_q.push_back({1'b0, 32'h0});
        wait_ack(1, ca);
        @(posedge clk); #1;
        bus.dm_we = 0; bus.dm_wdata = '0;
        dm_q.push_back({1'b1, 32'h12345678});
        wait_ack(1, cb);
        @(posedge clk); #1 bus.dm_req = 0;
        check("t2_ack_gap",  64'(cb - ca), 64'd5);
        check("t2_writes",   64'(wr_cnt - w0), 64'd1);
        check("t2_strobes",  64'(en_cnt - e0), 64'd2);
        check("t2_dm_rdata", 64'(bus.dm_rdata), 64'h12345678);

        // Simultaneous requests: data first, fetch 5 cycles later
        @(posedge clk); #1;
        c0 = cyc;
        bus.if_req = 1; bus.if_addr = 32'h104;
        if_q.push_back({1'b1, init_word('h41)});
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h80;
        dm_q.push_back({1'b1, init_word('h20)});
        fork
            begin wait_ack(1, cd); @(posedge clk); #1 bus.dm_req = 0; end
            begin wait_ack(0, ci); @(posedge clk); #1 bus.if_req = 0; end
        join
        check("t3_dm_first", 64'(cd - c0), 64'd4);
        check("t3_if_gap",   64'(ci - cd), 64'd5);

        // Starvation: four data grants, one fetch, then data resumes
        @(posedge clk); #1;
        ack_log.delete();
        bus.if_req = 1; bus.if_addr = 32'h108;
        if_q.push_back({1'b1, init_word('h42)});
        bus.dm_req = 1; bus.dm_addr = 32'h84;
        dm_q.push_back({1'b1, init_word('h21)});
        fork
            begin
                wait_ack(0, ci);
                check("t4_starve_clr", 64'(dut.starve_cnt), 64'd0);
                @(posedge clk); #1 bus.if_req = 0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    wait_ack(1, cd);
                    @(posedge clk); #1;
                    if (k < 5) begin
                        bus.dm_addr = 32'h88 + 32'(4 * k);
                        dm_q.push_back({1'b1, init_word('h22 + k)});
                    end else begin
                        bus.dm_req = 0;
                    end
                end
            end
        join
        check("t4_grants", 64'(ack_log.size()), 64'd7);
        for (int i = 0; i < 7 && i < ack_log.size(); i++)
            check($sformatf("t4_order_%0d", i), 64'(ack_log[i]), 64'(exp_order[i]));

        // Reset during WAIT aborts the transaction
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h10C;
        repeat (2) @(posedge clk); #1;
        @(negedge clk);
        check("t5_busy_in_wait", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        rst_n = 0; bus.if_req = 0;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("t5_mem_en",  64'(bus.mem_en), 64'd0);
        check("t5_busy",    64'(bus.busy), 64'd0);
        check("t5_rdata",   64'({bus.if_rdata, bus.dm_rdata}), 64'd0);
        check("t5_addr",    64'(bus.mem_addr), 64'd0);
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.if_ack || bus.dm_ack) acks++;
        end
        check("t5_no_ack", 64'(acks), 64'd0);
        @(posedge clk); #1;
        c0 = cyc;
        bus.if_req = 1;
        if_q.push_back({1'b1, init_word('h43)});
        wait_ack(0, ci);
        @(posedge clk); #1 bus.if_req = 0;
        check("t5_reack_cycle", 64'(ci - c0), 64'd4);

        // MEM_LAT = 1 build: single load
        @(posedge clk); #1;
        c0 = cyc; e0 = en1_cnt;
        bus1.dm_req = 1; bus1.dm_we = 0; bus1.dm_addr = 32'h44;
        dm1_q.push_back({1'b1, init_word('h11)});
        wait_ack(2, cd);
        @(posedge clk); #1 bus1.dm_req = 0;
        check("t6_ack_cycle", 64'(cd - c0), 64'd3);
        check("t6_strobes",   64'(en1_cnt - e0), 64'd1);

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(if_q.size() + dm_q.size() + dm1_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Shared single-port memory arbiter for the five-stage pipeline. It multiplexes instruction-fetch reads (IF stage) and data loads/stores (MEM stage) onto one synchronous memory port with fixed read latency. It runs one transaction at a time and acknowledges each requester. It also produces per-requester stall levels that feed the pipeline stall/flush logic alongside `stall_pc`/`stall_id`.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 2, cycles from the `mem_en` cycle to the cycle `mem_rdata` is valid (≥1)
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (≥1)

- `clk` in 1 — the single clock
- `rst_n` in 1 — reset; synchronous, active-low
- `if_req` in 1 — fetch request; held with `if_addr` until `if_ack`
- `if_addr` in AW — fetch address
- `if_ack` out 1 — one-cycle pulse; `if_rdata` valid in the same cycle
- `if_rdata` out DW — fetched word (registered)
- `if_stall` out 1 — `if_req & ~if_ack`
- `dm_req` in 1 — data request; held with its fields until `dm_ack`
- `dm_we` in 1 — 1 = store, 0 = load
- `dm_addr` in AW — data address
- `dm_wdata` in DW — store data
- `dm_ack` out 1 — one-cycle pulse
- `dm_rdata` out DW — load data (registered; holds the captured word on stores too)
- `dm_stall` out 1 — `dm_req & ~dm_ack`
- `mem_en` out 1 — memory access strobe, exactly one cycle per transaction
- `mem_we` out 1 — memory write enable; valid only with `mem_en`
- `mem_addr` out AW — memory address (registered)
- `mem_wdata` out DW — memory write data (registered)
- `mem_rdata` in DW — memory read data
- `busy` out 1 — state ≠ IDLE

## Operation
- FSM states are IDLE, ACCESS, WAIT and RESP.
- IDLE:
  - If any request is present, the arbiter picks a winner and captures the winner's address, write data and we, plus a `gnt_d` flag, into the `mem_*` registers. Next state is ACCESS.
  - With no request, the FSM stays in IDLE.
- Arbitration:
  - With a single request, that requester wins.
  - With both requests, data wins (it is the older instruction), unless `starve_cnt == STARVE_MAX`, in which case fetch wins.
- `starve_cnt` update:
  - +1 (saturating at STARVE_MAX) when data is granted while `if_req` = 1.
  - Cleared when fetch is granted, or when data is granted with `if_req` = 0.
- ACCESS (one cycle): `mem_en` = 1 and `mem_we` = the captured we. Next state is WAIT and the latency counter is loaded to MEM_LAT-1.
- WAIT (MEM_LAT cycles):
  - The counter decrements each cycle.
  - At count 0, `mem_rdata` is latched into `if_rdata` or `dm_rdata` according to `gnt_d`; the other data register is unchanged. Next state is RESP.
- RESP (one cycle): pulse `if_ack` or `dm_ack` for the winner only. Next state is always IDLE, so a request still high during RESP is never re-granted.
- Stores take the full sequence; the memory ignores `mem_rdata` for writes, and `dm_rdata` takes whatever is present.
- A requester that drops `req` before its ack violates the protocol. The transaction still completes and the ack still pulses.

## Timing
- Reset (`rst_n` = 0 at a clock edge):
  - State goes to IDLE.
  - `mem_en`, `mem_we`, `if_ack`, `dm_ack` and `busy` go to 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` and `starve_cnt` go to 0.
- Reset mid-transaction aborts it: no ack is issued, and `mem_en` is 0 from the next cycle. Requesters re-present after reset.
- Cycle sequence, with the request sampled in IDLE at the end of cycle 0:
  - ACCESS in cycle 1.
  - WAIT in cycles 2..MEM_LAT+1; capture at the end of cycle MEM_LAT+1.
  - Ack in cycle MEM_LAT+2.
  - With MEM_LAT = 2, ack lands in cycle 4.
- Throughput: IDLE is re-entered in cycle MEM_LAT+3, so with requests waiting, one transaction takes MEM_LAT+3 cycles.
- `if_stall`/`dm_stall` are combinational from `req` and the registered ack. They are 1 from the first request cycle through the cycle before ack, and 0 in the ack cycle.
- The memory contract is that it samples `mem_addr`/`mem_we`/`mem_wdata` at the end of the `mem_en` cycle, and `mem_rdata` is valid in cycle (`mem_en` cycle + MEM_LAT).

## Test plan
- Single fetch: `if_req` = 1 with `if_addr` = 0x100 and memory word 0xDEADBEEF, MEM_LAT = 2.
  - Expect `mem_en` in cycle 1 with `mem_addr` = 0x100 and `mem_we` = 0.
  - Expect `if_ack` in cycle 4 with `if_rdata` = 0xDEADBEEF.
  - `if_stall` = 1 in cycles 0–3.
- Store then load: store 0x12345678 to 0x40, then load from 0x40.
  - Expect exactly one `mem_en` with `mem_we` = 1 for the store.
  - Expect `dm_ack` twice, 5 cycles apart.
  - Final `dm_rdata` = 0x12345678.
- Simultaneous fetch and data requests, both held: expect data granted first; fetch is acked 5 cycles after `dm_ack`.
- Starvation with STARVE_MAX = 4: `if_req` held while `dm_req` reasserts immediately after each ack.
  - Expect 4 data grants, then 1 fetch grant, then `starve_cnt` = 0 and data resumes.
- Reset during WAIT: deassert `rst_n` for 1 cycle.
  - Expect no ack, all outputs 0, and state IDLE.
  - A re-presented request completes normally.
- MEM_LAT = 1 build: single load. Expect ack in cycle 3 and `mem_en` high for exactly 1 cycle.
